// File: rtl/cia_seq_adder_ctrl_pkg.sv
// Shared types and elaboration helpers for the sequential carry-increment adder controller.
package cia_seq_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ctrlState_t;

    localparam int DEFAULT_N  = 32;
    localparam int DEFAULT_GS = 4;

    function automatic bit paramsOk(input int n, input int gs);
        return (gs >= 2) && (n > 0) && ((n % gs) == 0);
    endfunction

    function automatic int groupCount(input int n, input int gs);
        return n / gs;
    endfunction

    // A single group still needs a one-bit index register.
    function automatic int idxWidth(input int ng);
        return (ng > 1) ? $clog2(ng) : 1;
    endfunction

endpackage

// File: rtl/cia_seq_adder_ctrl_group_slice.sv
// One GS-bit group: black-cell prefix for group G/P plus carry-increment sum.
module cia_group_slice #(
    parameter int GS = 4
) (
    input  logic [GS-1:0] aSlice,
    input  logic [GS-1:0] bSlice,
    input  logic          carryIn,
    output logic          groupG,
    output logic          groupP,
    output logic [GS-1:0] groupSum,
    output logic          carryOut
);

    logic [GS-1:0] partialSum;

    always_comb begin
        groupG = aSlice[0] & bSlice[0];
        groupP = aSlice[0] ^ bSlice[0];
        for (int j = 1; j < GS; j++) begin
            groupG = (aSlice[j] & bSlice[j]) | ((aSlice[j] ^ bSlice[j]) & groupG);
            groupP = groupP & (aSlice[j] ^ bSlice[j]);
        end
    end

    // The group's own carry is discarded here; it reappears through groupG.
    assign partialSum = aSlice + bSlice;
    assign groupSum   = partialSum + GS'(carryIn);
    assign carryOut   = groupG | (groupP & carryIn);

endmodule

// File: rtl/cia_seq_adder_ctrl.sv
// Sequencing controller: accepts one N-bit add, resolves one GS-bit group per cycle, then holds the result.
module cia_seq_adder_ctrl
    import cia_seq_adder_ctrl_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int GS = DEFAULT_GS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N-1:0]                   a,
    input  logic [N-1:0]                   b,
    input  logic                           cin,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N-1:0]                   sum,
    output logic                           cout,
    output logic [groupCount(N, GS)-1:0]   grp_g,
    output logic [groupCount(N, GS)-1:0]   grp_p,
    output logic                           busy
);

    localparam int NG    = groupCount(N, GS);
    localparam int IDX_W = idxWidth(NG);

    if (!paramsOk(N, GS)) begin : gParamCheck
        $error("cia_seq_adder_ctrl: N must be a multiple of GS and GS must be at least 2");
    end

    ctrlState_t       state;
    ctrlState_t       nextState;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [N-1:0]     opA;
    logic [N-1:0]     opB;
    logic [GS-1:0]    aSlice;
    logic [GS-1:0]    bSlice;
    logic             groupG;
    logic             groupP;
    logic [GS-1:0]    groupSum;
    logic             carryOut;
    logic             lastGroup;

    assign aSlice    = opA[idx*GS +: GS];
    assign bSlice    = opB[idx*GS +: GS];
    assign lastGroup = (idx == IDX_W'(NG - 1));

    cia_group_slice #(.GS(GS)) uSlice (
        .aSlice   (aSlice),
        .bSlice   (bSlice),
        .carryIn  (carry),
        .groupG   (groupG),
        .groupP   (groupP),
        .groupSum (groupSum),
        .carryOut (carryOut)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nextState = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (lastGroup) nextState = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Results stay put after the output handshake until the next request is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            opA   <= '0;
            opB   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            grp_g <= '0;
            grp_p <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opA   <= a;
                        opB   <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        grp_g <= '0;
                        grp_p <= '0;
                    end
                end
                RUN: begin
                    sum[idx*GS +: GS] <= groupSum;
                    grp_g[idx]        <= groupG;
                    grp_p[idx]        <= groupP;
                    carry             <= carryOut;
                    if (lastGroup) cout <= carryOut;
                    else           idx  <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cia_seq_adder_ctrl.sv
// Directed and randomized bench for cia_seq_adder_ctrl with an arithmetic reference model.
module tb_cia_seq_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b0, cout, busy;
    logic [31:0] a = '0, b = '0, sum;
    logic [7:0]  grp_g, grp_p;

    logic        in_valid2 = 1'b0, in_ready2, cin2 = 1'b0, out_valid2, out_ready2 = 1'b0, cout2, busy2;
    logic [15:0] a2 = '0, b2 = '0, sum2;
    logic [1:0]  grp_g2, grp_p2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cia_seq_adder_ctrl #(.N(32), .GS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .grp_g(grp_g), .grp_p(grp_p), .busy(busy)
    );

    cia_seq_adder_ctrl #(.N(16), .GS(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .grp_g(grp_g2), .grp_p(grp_p2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-word addition plus per-group arithmetic: a group generates when its
    // two slices overflow, and propagates when they sum to exactly all ones.
    function automatic void refModel(input int n, input int gs,
                                     input longint unsigned av, input longint unsigned bv, input bit c,
                                     output longint unsigned s, output bit co,
                                     output longint unsigned g, output longint unsigned p);
        longint unsigned tot, gmask, ak, bk;
        tot   = av + bv + 64'(c);
        s     = tot & ((64'd1 << n) - 64'd1);
        co    = tot[n];
        g     = 0;
        p     = 0;
        gmask = (64'd1 << gs) - 64'd1;
        for (int k = 0; k < n / gs; k++) begin
            ak = (av >> (k * gs)) & gmask;
            bk = (bv >> (k * gs)) & gmask;
            if (((ak + bk) >> gs) != 0) g |= (64'd1 << k);
            if ((ak + bk) == gmask)     p |= (64'd1 << k);
        end
    endfunction

    task automatic runOp(input logic [31:0] av, input logic [31:0] bv, input logic c,
                         input int holdCycles, input bit pulseInputs);
        longint unsigned es, eg, ep;
        bit eco;
        int lat;
        refModel(32, 4, 64'(av), 64'(bv), c, es, eco, eg, ep);
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        a = av; b = bv; cin = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_run", 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency_edges", 64'(lat), 64'd8);
        check("sum", 64'(sum), es);
        check("cout", 64'(cout), 64'(eco));
        check("grp_g", 64'(grp_g), eg);
        check("grp_p", 64'(grp_p), ep);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            if (pulseInputs) begin
                a = $urandom; b = $urandom; cin = 1'($urandom); in_valid = 1'b1;
            end
            @(posedge clk); #1;
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_sum", 64'(sum), es);
            check("hold_cout", 64'(cout), 64'(eco));
            check("hold_grp_g", 64'(grp_g), eg);
            check("hold_grp_p", 64'(grp_p), ep);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_sum_kept", 64'(sum), es);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] qa [4];
        logic [31:0] qb [4];
        bit          qc [4];
        longint unsigned es, eg, ep;
        bit eco;
        int nAcc, nOut, cyc, lastAcc, lat;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_grp_g", 64'(grp_g), 64'd0);
        check("rst_grp_p", 64'(grp_p), 64'd0);
        check("rst2_busy", 64'(busy2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Spec vectors, checked against literal constants as well as the model.
        runOp(32'hFFFF_FFFF, 32'h1, 1'b0, 0, 1'b0);
        check("v1_sum", 64'(sum), 64'h0);
        check("v1_cout", 64'(cout), 64'd1);
        check("v1_grp_g", 64'(grp_g), 64'h01);
        check("v1_grp_p", 64'(grp_p), 64'hFE);
        runOp(32'h1234_5678, 32'h1111_1111, 1'b1, 0, 1'b0);
        check("v2_sum", 64'(sum), 64'h2345_678A);
        check("v2_cout", 64'(cout), 64'd0);

        // Carry ripples through every group, and the maximum-input case.
        runOp(32'h0, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
        runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);

        // Backpressure with new operands offered while DONE.
        runOp($urandom, $urandom, 1'($urandom), 5, 1'b1);

        // Reset in the middle of RUN.
        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_grp_g", 64'(grp_g), 64'd0);
        check("midrst_grp_p", 64'(grp_p), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp(32'hCAFE_1234, 32'h3501_EDCB, 1'b1, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            runOp($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Back-to-back with out_ready tied high.
        for (int i = 0; i < 4; i++) begin
            qa[i] = $urandom; qb[i] = $urandom; qc[i] = 1'($urandom);
        end
        nAcc = 0; nOut = 0; cyc = 0; lastAcc = 0;
        out_ready = 1'b1;
        while (nOut < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                refModel(32, 4, 64'(qa[nOut]), 64'(qb[nOut]), qc[nOut], es, eco, eg, ep);
                check("b2b_sum", 64'(sum), es);
                check("b2b_cout", 64'(cout), 64'(eco));
                check("b2b_grp_g", 64'(grp_g), eg);
                nOut++;
            end
            if (nAcc < 4) begin
                in_valid = 1'b1;
                if (in_ready) begin
                    a = qa[nAcc]; b = qb[nAcc]; cin = qc[nAcc];
                    if (nAcc > 0) check("b2b_issue_interval", 64'(cyc - lastAcc), 64'd10);
                    lastAcc = cyc;
                    nAcc++;
                end else begin
                    a = $urandom; b = $urandom; cin = 1'($urandom);
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        check("b2b_results_seen", 64'(nOut), 64'd4);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;

        // Two 8-bit groups.
        @(negedge clk);
        check("n16_in_ready", 64'(in_ready2), 64'd1);
        a2 = 16'h00FF; b2 = 16'h0001; cin2 = 1'b0; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("n16_latency_edges", 64'(lat), 64'd2);
        check("n16_sum", 64'(sum2), 64'h0100);
        check("n16_cout", 64'(cout2), 64'd0);
        check("n16_grp_g", 64'(grp_g2), 64'h1);
        check("n16_grp_p", 64'(grp_p2), 64'h0);
        @(negedge clk);
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        check("n16_release", 64'(out_valid2), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
